// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - raster constants and fetch FSM state type
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int LINE     = 799;
  localparam int SCREEN   = 524;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - line base address, issue counter and registered burst address
module burst_addr_gen #(
  parameter int LINE_BYTES  = 1280,
  parameter int BURST_BYTES = 128,
  parameter int BURSTS      = 10
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        load,
  input  logic        load_base,
  input  logic [31:0] fb_base,
  input  logic        advance,
  output logic [31:0] req_addr,
  output logic [3:0]  req_idx,
  output logic        last_burst
);

  logic [31:0] line_addr;
  logic [31:0] next_line;
  logic [3:0]  issue_cnt;

  assign next_line  = load_base ? fb_base : line_addr + 32'(LINE_BYTES);
  assign req_idx    = issue_cnt;
  assign last_burst = (issue_cnt == 4'(BURSTS - 1));

  // req_addr advances by one burst per handshake so it is always line_addr + idx*BURST_BYTES
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      line_addr <= '0;
      issue_cnt <= '0;
      req_addr  <= '0;
    end else if (load) begin
      line_addr <= next_line;
      issue_cnt <= '0;
      req_addr  <= next_line;
    end else if (advance && !last_burst) begin
      issue_cnt <= issue_cnt + 4'd1;
      req_addr  <= req_addr + 32'(BURST_BYTES);
    end
  end

endmodule

// File: rtl/line_fetch_ctrl.sv
// rtl/line_fetch_ctrl.sv - schedules framebuffer burst reads ahead of the beam into a
// two-line ping-pong buffer and flags lines that start before their data arrived
module line_fetch_ctrl #(
  parameter int H_ACTIVE    = video_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = video_timing_pkg::V_ACTIVE,
  parameter int SCREEN      = video_timing_pkg::SCREEN,
  parameter int LINE_BYTES  = 1280,
  parameter int BURST_BYTES = 128,
  parameter int BURSTS      = LINE_BYTES / BURST_BYTES
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [9:0]  screen_x,
  input  logic [9:0]  screen_y,
  input  logic        enable,
  input  logic [31:0] fb_base,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_buf,
  output logic [3:0]  req_idx,
  input  logic        rd_done,
  output logic [1:0]  line_ready,
  output logic        underrun,
  input  logic        underrun_clr
);

  import video_timing_pkg::fetch_state_e;
  import video_timing_pkg::ST_IDLE;
  import video_timing_pkg::ST_ISSUE;
  import video_timing_pkg::ST_DRAIN;
  import video_timing_pkg::LINE;

  if (BURSTS > 16 || BURSTS * BURST_BYTES != LINE_BYTES || LINE_BYTES < H_ACTIVE) begin : g_bad_cfg
    $error("line_fetch_ctrl: unsupported burst geometry");
  end

  fetch_state_e state;
  logic [4:0]   done_cnt;
  logic         first_line;
  logic         trigger;
  logic         start;
  logic         tgt_buf;
  logic         handshake;
  logic         last_burst;
  logic         fetch_done;
  logic         line_end;
  logic         line_check;
  logic [1:0]   ready_set;
  logic [1:0]   ready_clr;

  assign first_line = (screen_y == 10'(SCREEN));
  assign trigger    = enable && (screen_x == 10'd0) &&
                      (first_line || screen_y < 10'(V_ACTIVE - 1));
  assign start      = (state == ST_IDLE) && trigger;
  // target line is y+1, or 0 from the last blanking line, so its buffer is the opposite parity
  assign tgt_buf    = first_line ? 1'b0 : ~screen_y[0];
  assign handshake  = req_valid && req_ready;
  assign fetch_done = (state == ST_DRAIN) && rd_done && (done_cnt == 5'(BURSTS - 1));
  assign line_end   = (screen_x == 10'(LINE)) && (screen_y < 10'(V_ACTIVE));
  assign line_check = enable && (screen_x == 10'd0) && (screen_y < 10'(V_ACTIVE));

  burst_addr_gen #(
    .LINE_BYTES (LINE_BYTES),
    .BURST_BYTES(BURST_BYTES),
    .BURSTS     (BURSTS)
  ) u_addr (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .load      (start),
    .load_base (first_line),
    .fb_base   (fb_base),
    .advance   (handshake),
    .req_addr  (req_addr),
    .req_idx   (req_idx),
    .last_burst(last_burst)
  );

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_buf   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (state != ST_IDLE && rd_done) done_cnt <= done_cnt + 5'd1;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state     <= ST_ISSUE;
            req_valid <= 1'b1;
            req_buf   <= tgt_buf;
            done_cnt  <= '0;
          end
        end
        ST_ISSUE: begin
          if (handshake && last_burst) begin
            state     <= ST_DRAIN;
            req_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (fetch_done) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ready_clr = 2'b00;
    ready_set = 2'b00;
    if (line_end) ready_clr[screen_y[0]] = 1'b1;
    if (start) ready_clr[tgt_buf] = 1'b1;
    if (fetch_done) ready_set[req_buf] = 1'b1;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      line_ready <= 2'b00;
      underrun   <= 1'b0;
    end else begin
      line_ready <= (line_ready & ~ready_clr) | ready_set;
      if (line_check && !line_ready[screen_y[0]]) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule
